data_mem_sys: RTL and testbench
===============================

# data_mem_sys

Data-side memory system attached to the CPU's data port: consumes `A`, `WD` and `mem_write` and returns `ReadData` combinationally within the same cycle, as the single-cycle core requires. It provides word-addressed data RAM, a memory-mapped byte-output FIFO with a valid/ready handshake to an external consumer, and an optional free-running 64-bit cycle counter. It sits directly downstream of the CPU's data port; instruction memory is separate.

## Interface
- `RAM_AW`, 10: log2 of RAM depth in 32-bit words (default 1024 words).
- `FIFO_AW`, 3: log2 of TX FIFO depth in bytes (default 8 entries).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; one clock, reset is asynchronous and active-high.
- `A`  in  32  byte address from the CPU; `A[1:0]` ignored (word access only).
- `WD`  in  32  store data.
- `mem_write`  in  1  store strobe, sampled at the rising edge.
- `ReadData`  out  32  combinational read data for `A`.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_data`  out  8  FIFO head byte; don't-care when `tx_valid`=0.
- `tx_ready`  in  1  consumer accepts the head byte when `tx_valid`&&`tx_ready`.

## Operation
- Decode:
  - RAM when `A[31:16]`==16'h0000. Word index `A[RAM_AW+1:2]`; upper unused bits aliased.
  - MMIO when `A[31:16]`==16'hFFFF, registers at `A[3:0]`.
  - Anything else reads 0; writes are ignored.
- RAM: asynchronous read; synchronous write of the full word on `mem_write`. Contents are not cleared by `rst` and are undefined at power-up.
- MMIO map:
  - 0x0 TXDATA: a write pushes `WD[7:0]`; reads return 0.
  - 0x4 STATUS: reads `{28'b0, overflow, full, empty, 1'b0}` at bits [3:0]. A write with `WD[3]`=1 clears `overflow`.
  - 0x8 CYCLE_LO: reads counter[31:0].
  - 0xC CYCLE_HI: reads counter[63:32]. Both are read-only.
- FIFO:
  - Circular buffer with `FIFO_AW`+1-bit read/write pointers. Full when the pointers differ only in the MSB; empty when they are equal.
  - A push is accepted when !full, or when full with a pop in the same cycle.
  - A rejected push sets sticky `overflow` and leaves FIFO contents unchanged.
  - A simultaneous push and pop on an empty FIFO is impossible, because a pop requires `tx_valid`.
- Pointers wrap modulo 2^(`FIFO_AW`+1).
- Reset (asynchronous): pointers = 0, `overflow` = 0, counter = 0.
  - Outputs after reset: `tx_valid`=0, `tx_data` don't-care, `ReadData` follows `A` (RAM, unchanged) or the MMIO state.
  - Reset asserted mid-transfer discards all queued bytes.

## Timing
- `ReadData` is purely combinational from `A` and the current state, so load latency is 0 cycles.
- Stores and pushes take effect at the rising edge while `mem_write`=1. A read of the same address in the next cycle returns the new value.
- The STATUS register reflects state before the current edge. A push in cycle N is visible as `tx_valid`=1 in cycle N+1.
- Pop: when `tx_valid`&&`tx_ready` at an edge, the head advances. `tx_data` shows the next byte in the following cycle. `tx_data` must stay stable while `tx_valid`=1 and `tx_ready`=0.
- The counter increments every cycle after reset release and wraps from 2^64-1 to 0. Reads are not snapshotted: software must handle LO carry itself.
- The overflow clear and a rejected push in the same cycle leave `overflow`=1 (set wins).

## Configuration
- `DMEM_CYCLE_COUNTER_EN`:
  - Defined: the 64-bit counter is instantiated and 0x8/0xC read it.
  - Undefined: no counter registers exist, and 0x8/0xC read 32'h0.
  - RAM and FIFO behaviour is identical either way.

## Test plan
- RAM store/load: write 32'hDEADBEEF to A=0x0000_0010 → next cycle ReadData=32'hDEADBEEF. A=0x0000_0013 also reads 32'hDEADBEEF. A=0x1234_0000 reads 0.
- FIFO ordering: with `tx_ready`=0, push 0x41,0x42,0x43 → STATUS=0x0, `tx_data`=0x41. Raise `tx_ready` → bytes 0x41,0x42,0x43 on consecutive cycles, then `tx_valid`=0 and STATUS=0x2.
- Full/overflow: push 8 bytes with `tx_ready`=0 → STATUS=0x4. Push a 9th → STATUS=0xC and `tx_data` still the first byte. Write STATUS with WD=0x8 → STATUS=0x4.
- Full with simultaneous push and pop: FIFO full, `tx_ready`=1, push 0x99 → accepted, `overflow` stays 0, 0x99 emerges 8th.
- Reset mid-operation: 5 bytes queued, assert `rst` asynchronously between edges → `tx_valid`=0 immediately, STATUS=0x2. RAM word previously written still reads back.
- Counter (macro defined): release reset, wait 100 cycles → CYCLE_LO=100±1, CYCLE_HI=0. Macro undefined → both read 0.

Source files
------------

// File: rtl/data_mem_sys_if.sv
// rtl/data_mem_sys_if.sv - CPU data port and TX byte stream bundle for data_mem_sys.
interface data_mem_sys_if;
  logic [31:0] A;
  logic [31:0] WD;
  logic        mem_write;
  logic [31:0] ReadData;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  modport master (
    output A, WD, mem_write, tx_ready,
    input  ReadData, tx_valid, tx_data
  );

  modport slave (
    input  A, WD, mem_write, tx_ready,
    output ReadData, tx_valid, tx_data
  );
endinterface

// File: rtl/data_mem_sys.sv
// rtl/data_mem_sys.sv - data RAM, MMIO TX byte FIFO and cycle counter on the CPU data port.
// Optional 64-bit cycle counter enabled by DMEM_CYCLE_COUNTER_EN.
module data_mem_sys #(
  parameter int RAM_AW  = 10,
  parameter int FIFO_AW = 3
) (
  input logic          clk,
  input logic          rst,
  data_mem_sys_if.slave bus
);
  localparam int FIFO_DEPTH = 1 << FIFO_AW;

  logic [31:0]      ram_q  [0:(1<<RAM_AW)-1];
  logic [7:0]       fifo_q [0:FIFO_DEPTH-1];
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
  logic             is_ram, is_mmio, full, empty;
  logic             push, pop, push_ok, ovf_clr;
  logic [RAM_AW-1:0] ram_idx;
  logic [63:0]      cycle;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^bus.A;

  always_comb begin
    is_ram   = (bus.A[31:16] == 16'h0000);
    is_mmio  = (bus.A[31:16] == 16'hFFFF);
    ram_idx  = bus.A[RAM_AW+1:2];
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {FIFO_AW{1'b0}}});
    pop      = !empty && bus.tx_ready;
    push     = bus.mem_write && is_mmio && (bus.A[3:2] == 2'd0);
    ovf_clr  = bus.mem_write && is_mmio && (bus.A[3:2] == 2'd1) && bus.WD[3];
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    push_ok  = push && (!full || pop);
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    overflow_d = (overflow_q && !ovf_clr) || (push && !push_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage arrays are never reset; only the pointers define valid contents.
  always_ff @(posedge clk) begin
    if (bus.mem_write && is_ram) ram_q[ram_idx] <= bus.WD;
    if (push_ok) fifo_q[wr_ptr_q[FIFO_AW-1:0]] <= bus.WD[7:0];
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [63:0] cnt_q, cnt_d;
  assign cnt_d = cnt_q + 64'd1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 64'd0;
    else     cnt_q <= cnt_d;
  end
  assign cycle = cnt_q;
`else
  assign cycle = 64'd0;
`endif

  assign bus.tx_valid = !empty;
  assign bus.tx_data  = fifo_q[rd_ptr_q[FIFO_AW-1:0]];

  always_comb begin
    bus.ReadData = 32'h0;
    if (is_ram) begin
      bus.ReadData = ram_q[ram_idx];
    end else if (is_mmio) begin
      case (bus.A[3:2])
        2'd1:    bus.ReadData = {28'h0, overflow_q, full, empty, 1'b0};
        2'd2:    bus.ReadData = cycle[31:0];
        2'd3:    bus.ReadData = cycle[63:32];
        default: bus.ReadData = 32'h0;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_sys.sv
// tb/tb_data_mem_sys.sv - directed self-checking bench for data_mem_sys.
module tb_data_mem_sys;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] TXDATA = 32'hFFFF_0000;
  localparam logic [31:0] STATUS = 32'hFFFF_0004;
  localparam logic [31:0] CYC_LO = 32'hFFFF_0008;
  localparam logic [31:0] CYC_HI = 32'hFFFF_000C;

  data_mem_sys_if bus ();

  data_mem_sys #(.RAM_AW(10), .FIFO_AW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus.A = addr;
    bus.WD = data;
    bus.mem_write = 1'b1;
    tick();
    bus.mem_write = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus.A = addr;
    #1;
    chk(tag, bus.ReadData, exp);
  endtask

  logic [7:0] exp_bytes [0:7];
  logic [31:0] cyc_exp;

  initial begin
    rst = 1'b1;
    bus.A = STATUS;
    bus.WD = 32'h0;
    bus.mem_write = 1'b0;
    bus.tx_ready = 1'b0;
    #1;
    chk("reset_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
    rd("reset_status", STATUS, 32'h2);
    tick();
    rst = 1'b0;

    // RAM store/load, alias, unmapped
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd("ram_load", 32'h0000_0010, 32'hDEAD_BEEF);
    rd("ram_low_bits", 32'h0000_0013, 32'hDEAD_BEEF);
    rd("ram_alias", 32'h0000_1010, 32'hDEAD_BEEF);
    rd("unmapped", 32'h1234_0000, 32'h0);
    wr(32'h1234_0000, 32'h5555_5555);
    rd("unmapped_wr", 32'h1234_0000, 32'h0);
    wr(32'h0000_0020, 32'h0123_4567);
    rd("ram_second", 32'h0000_0020, 32'h0123_4567);
    rd("ram_first_kept", 32'h0000_0010, 32'hDEAD_BEEF);

    // FIFO ordering
    wr(TXDATA, 32'h41);
    wr(TXDATA, 32'h42);
    wr(TXDATA, 32'h43);
    rd("fifo3_status", STATUS, 32'h0);
    rd("txdata_reads0", TXDATA, 32'h0);
    chk("fifo3_head", {24'h0, bus.tx_data}, 32'h41);
    tick();
    chk("head_stable", {24'h0, bus.tx_data}, 32'h41);
    bus.tx_ready = 1'b1;
    tick();
    chk("pop1", {24'h0, bus.tx_data}, 32'h42);
    tick();
    chk("pop2", {24'h0, bus.tx_data}, 32'h43);
    tick();
    chk("drained_valid", {31'h0, bus.tx_valid}, 32'h0);
    rd("drained_status", STATUS, 32'h2);
    bus.tx_ready = 1'b0;

    // Full and overflow
    for (int i = 0; i < 8; i++) wr(TXDATA, 32'h10 + i);
    rd("full_status", STATUS, 32'h4);
    wr(TXDATA, 32'h99);
    rd("overflow_status", STATUS, 32'hC);
    chk("overflow_head", {24'h0, bus.tx_data}, 32'h10);
    wr(STATUS, 32'h8);
    rd("ovf_clear", STATUS, 32'h4);

    // Full with simultaneous push and pop
    bus.tx_ready = 1'b1;
    wr(TXDATA, 32'h99);
    rd("push_pop_status", STATUS, 32'h4);
    for (int i = 0; i < 7; i++) exp_bytes[i] = 8'h11 + 8'(i);
    exp_bytes[7] = 8'h99;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("pp_byte%0d", i), {24'h0, bus.tx_data}, {24'h0, exp_bytes[i]});
      tick();
    end
    chk("pp_empty", {31'h0, bus.tx_valid}, 32'h0);
    rd("pp_status", STATUS, 32'h2);
    bus.tx_ready = 1'b0;

    // Asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) wr(TXDATA, 32'h60 + i);
    bus.A = STATUS;
    #2;
    chk("pre_rst_valid", {31'h0, bus.tx_valid}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_valid", {31'h0, bus.tx_valid}, 32'h0);
    rd("rst_status", STATUS, 32'h2);
    rd("rst_ram_kept", 32'h0000_0010, 32'hDEAD_BEEF);
    rst = 1'b0;

    // Cycle counter: reset released mid-cycle, then 100 rising edges
    bus.A = CYC_LO;
    repeat (100) @(posedge clk);
    #1;
`ifdef DMEM_CYCLE_COUNTER_EN
    cyc_exp = 32'd100;
`else
    cyc_exp = 32'd0;
`endif
    rd("cycle_lo", CYC_LO, cyc_exp);
    rd("cycle_hi", CYC_HI, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
